// File: rtl/l2_cache_pkg.sv
// Shared types and width helpers for the set-associative L2 cache.
package l2_cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL,
    S_RESPOND
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

  function automatic int off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_w, input int num_sets);
    return addr_w - idx_w(num_sets) - off_w(line_w);
  endfunction

  // A one-way cache still needs a 1-bit way index to keep vectors legal.
  function automatic int way_w(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

endpackage

// File: rtl/l2_lru_ages.sv
// True-LRU age table: one age per way per set, age 0 = most recently used.
module l2_lru_ages
  import l2_cache_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [idx_w(NUM_SETS)-1:0]     idx,
  input  logic                           touch,
  input  logic [way_w(NUM_WAYS)-1:0]     touch_way,
  output logic [way_w(NUM_WAYS)-1:0]     oldest_way
);

  localparam int WAY_W = way_w(NUM_WAYS);

  logic [WAY_W-1:0] ages [NUM_SETS][NUM_WAYS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          ages[s][w] <= WAY_W'(w);
        end
      end
    end else if (touch) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == touch_way) begin
          ages[idx][w] <= '0;
        end else if (ages[idx][w] < ages[idx][touch_way]) begin
          ages[idx][w] <= ages[idx][w] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    oldest_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (ages[idx][w] == WAY_W'(NUM_WAYS - 1)) begin
        oldest_way = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/l2_cache_assoc.sv
// N-way set-associative write-back / write-allocate L2 with true-LRU replacement.
// Optional performance counters: define L2_PERF_CNT_EN.
module l2_cache_assoc
  import l2_cache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] write_data,
  output logic [LINE_W-1:0] read_data,
  output logic              ready,
  output logic              l2_hit,
  output logic              l2_miss,
  output logic              mem_read_req,
  output logic              mem_write_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_write_data,
  input  logic [LINE_W-1:0] mem_read_data,
  input  logic              mem_ready
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       wb_cnt
`endif
);

  localparam int OFF_W = off_w(LINE_W);
  localparam int IDX_W = idx_w(NUM_SETS);
  localparam int TAG_W = tag_w(ADDR_W, LINE_W, NUM_SETS);
  localparam int WAY_W = way_w(NUM_WAYS);

  state_t state, state_next;
  op_t    op;

  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_data;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WAY_W-1:0]  victim;

  logic [TAG_W-1:0]    tag_mem  [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]   data_mem [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid    [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty    [NUM_SETS];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_any;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] victim_sel;
  logic [WAY_W-1:0] lru_oldest;
  logic             victim_dirty;
  logic             touch;
  logic [WAY_W-1:0] touch_way;

  // Line offset bits of the request address are don't-care.
  logic unused_offset;
  assign unused_offset = ^addr[OFF_W-1:0];

  assign idx     = req_addr[OFF_W +: IDX_W];
  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (valid[idx][w] && tag_mem[idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Scan downwards so the lowest-index invalid way wins.
    for (int unsigned w = NUM_WAYS; w > 0; w--) begin
      if (!valid[idx][w-1]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w - 1);
      end
    end
    victim_sel   = inv_any ? inv_way : lru_oldest;
    victim_dirty = valid[idx][victim_sel] && dirty[idx][victim_sel];
  end

  always_comb begin
    touch     = 1'b0;
    touch_way = victim;
    unique case (state)
      S_LOOKUP: begin
        touch     = hit;
        touch_way = hit_way;
      end
      S_REFILL:  touch = mem_ready;
      S_RESPOND: touch = (op == OP_WRITE);
      default:   touch = 1'b0;
    endcase
  end

  l2_lru_ages #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_lru (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx),
    .touch      (touch),
    .touch_way  (touch_way),
    .oldest_way (lru_oldest)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:
        if (read_req || write_req) state_next = S_LOOKUP;
      S_LOOKUP:
        if (hit)                 state_next = S_IDLE;
        else if (victim_dirty)   state_next = S_WRITEBACK;
        else if (op == OP_READ)  state_next = S_REFILL;
        else                     state_next = S_RESPOND;
      S_WRITEBACK:
        if (mem_ready) state_next = (op == OP_READ) ? S_REFILL : S_RESPOND;
      S_REFILL:
        if (mem_ready) state_next = S_RESPOND;
      S_RESPOND:
        state_next = S_IDLE;
      default:
        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      op             <= OP_READ;
      req_addr       <= '0;
      req_data       <= '0;
      victim         <= '0;
      read_data      <= '0;
      ready          <= 1'b0;
      l2_hit         <= 1'b0;
      l2_miss        <= 1'b0;
      mem_read_req   <= 1'b0;
      mem_write_req  <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
      end
    end else begin
      state   <= state_next;
      ready   <= 1'b0;
      l2_hit  <= 1'b0;
      l2_miss <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (read_req || write_req) begin
            req_addr <= addr;
            req_data <= write_data;
            op       <= read_req ? OP_READ : OP_WRITE;
          end
        end
        S_LOOKUP: begin
          victim <= victim_sel;
          if (hit) begin
            ready  <= 1'b1;
            l2_hit <= 1'b1;
            if (op == OP_READ) begin
              read_data <= data_mem[idx][hit_way];
            end else begin
              data_mem[idx][hit_way] <= req_data;
              dirty[idx][hit_way]    <= 1'b1;
            end
          end else begin
            l2_miss <= 1'b1;
            if (victim_dirty) begin
              mem_write_req  <= 1'b1;
              mem_addr       <= {tag_mem[idx][victim_sel], idx, {OFF_W{1'b0}}};
              mem_write_data <= data_mem[idx][victim_sel];
            end else if (op == OP_READ) begin
              mem_read_req <= 1'b1;
              mem_addr     <= {req_tag, idx, {OFF_W{1'b0}}};
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ready) begin
            mem_write_req       <= 1'b0;
            valid[idx][victim]  <= 1'b0;
            dirty[idx][victim]  <= 1'b0;
            // Write and read requests swap on the same edge, never overlapping.
            if (op == OP_READ) begin
              mem_read_req <= 1'b1;
              mem_addr     <= {req_tag, idx, {OFF_W{1'b0}}};
            end
          end
        end
        S_REFILL: begin
          if (mem_ready) begin
            mem_read_req            <= 1'b0;
            tag_mem[idx][victim]    <= req_tag;
            data_mem[idx][victim]   <= mem_read_data;
            valid[idx][victim]      <= 1'b1;
            dirty[idx][victim]      <= 1'b0;
            read_data               <= mem_read_data;
          end
        end
        S_RESPOND: begin
          ready <= 1'b1;
          if (op == OP_WRITE) begin
            tag_mem[idx][victim]  <= req_tag;
            data_mem[idx][victim] <= req_data;
            valid[idx][victim]    <= 1'b1;
            dirty[idx][victim]    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef L2_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (state == S_LOOKUP && hit && hit_cnt != '1)     hit_cnt  <= hit_cnt + 1'b1;
      if (state == S_LOOKUP && !hit && miss_cnt != '1)   miss_cnt <= miss_cnt + 1'b1;
      if (state == S_WRITEBACK && mem_ready && wb_cnt != '1) wb_cnt <= wb_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_cache_assoc.sv
// Randomized bench for l2_cache_assoc against a recency-list cache model and a memory image.
module tb_l2_cache_assoc;

  localparam int LW = 128;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          read_req = 1'b0;
  logic          write_req = 1'b0;
  logic [31:0]   addr = '0;
  logic [LW-1:0] write_data = '0;
  logic [LW-1:0] read_data;
  logic          ready;
  logic          l2_hit;
  logic          l2_miss;
  logic          mem_read_req;
  logic          mem_write_req;
  logic [31:0]   mem_addr;
  logic [LW-1:0] mem_write_data;
  logic [LW-1:0] mem_read_data = '0;
  logic          mem_ready = 1'b0;

  int n_checks = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0]   la;
    logic [LW-1:0] data;
    bit            dirty;
  } line_t;

  // Cache model: every resident line, most recently used first.
  line_t lines[$];
  logic [LW-1:0] mem_q [logic [31:0]];

  l2_cache_assoc #(
    .ADDR_W   (32),
    .LINE_W   (LW),
    .NUM_SETS (64),
    .NUM_WAYS (NW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .read_req       (read_req),
    .write_req      (write_req),
    .addr           (addr),
    .write_data     (write_data),
    .read_data      (read_data),
    .ready          (ready),
    .l2_hit         (l2_hit),
    .l2_miss        (l2_miss),
    .mem_read_req   (mem_read_req),
    .mem_write_req  (mem_write_req),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_ready      (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] mem_rd(input logic [31:0] la);
    if (mem_q.exists(la)) return mem_q[la];
    return {la ^ 32'h0BAD_F00D, la, ~la, la + 32'h1234_5678};
  endfunction

  function automatic int set_of(input logic [31:0] la);
    return int'(la[9:4]);
  endfunction

  task automatic do_op(input bit is_wr, input logic [31:0] a, input logic [LW-1:0] d);
    logic [31:0]   la;
    int            idx, cnt, vic;
    bit            exp_hit, exp_wb, exp_rf;
    logic [31:0]   exp_wb_addr, exp_rf_addr;
    logic [LW-1:0] exp_wb_data, exp_rd;
    line_t         ln;
    int            hits, misses, both, lat, dly;
    bit            wb_seen, rf_seen, done;
    logic [31:0]   wb_addr, rf_addr;
    logic [LW-1:0] wb_data, rd;

    la = a & ~32'hF;
    idx = -1;
    for (int i = 0; i < lines.size(); i++) if (lines[i].la == la) idx = i;
    exp_hit = (idx >= 0);
    exp_wb = 0; exp_rf = 0; exp_wb_addr = '0; exp_rf_addr = '0; exp_wb_data = '0; exp_rd = '0;
    if (exp_hit) begin
      ln = lines[idx];
      lines.delete(idx);
      if (is_wr) begin ln.data = d; ln.dirty = 1; end
      exp_rd = ln.data;
      lines.push_front(ln);
    end else begin
      cnt = 0; vic = -1;
      for (int i = 0; i < lines.size(); i++)
        if (set_of(lines[i].la) == set_of(la)) begin cnt++; vic = i; end
      if (cnt == NW) begin
        if (lines[vic].dirty) begin
          exp_wb = 1; exp_wb_addr = lines[vic].la; exp_wb_data = lines[vic].data;
        end
        lines.delete(vic);
      end
      ln.la = la;
      if (is_wr) begin
        ln.data = d; ln.dirty = 1;
      end else begin
        exp_rf = 1; exp_rf_addr = la; ln.data = mem_rd(la); ln.dirty = 0; exp_rd = ln.data;
      end
      lines.push_front(ln);
    end

    @(negedge clk);
    read_req = !is_wr; write_req = is_wr; addr = a; write_data = d;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    read_req = 0; write_req = 0; mem_ready = 0;
    hits = 0; misses = 0; both = 0; lat = 0; dly = 0;
    wb_seen = 0; rf_seen = 0; done = 0; wb_addr = '0; rf_addr = '0; wb_data = '0; rd = '0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      mem_ready = 0;
      if (l2_hit) hits++;
      if (l2_miss) misses++;
      if (mem_read_req && mem_write_req) both++;
      if (mem_write_req) begin
        if (!wb_seen) begin
          wb_seen = 1; wb_addr = mem_addr; wb_data = mem_write_data; dly = $urandom_range(0, 3);
        end
        if (dly == 0) begin mem_ready = 1; mem_q[mem_addr] = mem_write_data; end
        else dly--;
      end else if (mem_read_req) begin
        if (!rf_seen) begin
          rf_seen = 1; rf_addr = mem_addr; dly = $urandom_range(0, 3);
        end
        if (dly == 0) begin mem_ready = 1; mem_read_data = mem_rd(mem_addr); end
        else dly--;
      end
      if (ready) begin done = 1; lat = c; rd = read_data; end
    end
    check_eq("done", LW'(done), LW'(1));
    check_eq("hit_pulse", LW'(hits), LW'(exp_hit));
    check_eq("miss_pulse", LW'(misses), LW'(!exp_hit));
    check_eq("wb_req", LW'(wb_seen), LW'(exp_wb));
    if (exp_wb && wb_seen) begin
      check_eq("wb_addr", LW'(wb_addr), LW'(exp_wb_addr));
      check_eq("wb_data", wb_data, exp_wb_data);
    end
    check_eq("rf_req", LW'(rf_seen), LW'(exp_rf));
    if (exp_rf && rf_seen) check_eq("rf_addr", LW'(rf_addr), LW'(exp_rf_addr));
    if (!is_wr && done) check_eq("read_data", rd, exp_rd);
    if (exp_hit && done) check_eq("hit_latency", LW'(lat), LW'(1));
    check_eq("req_overlap", LW'(both), LW'(0));
    @(negedge clk);
    check_eq("ready_single", LW'(ready), LW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          st;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", LW'(ready), LW'(0));
    check_eq("rst_hit", LW'(l2_hit), LW'(0));
    check_eq("rst_miss", LW'(l2_miss), LW'(0));
    check_eq("rst_mrd", LW'(mem_read_req), LW'(0));
    check_eq("rst_mwr", LW'(mem_write_req), LW'(0));
    check_eq("rst_maddr", LW'(mem_addr), LW'(0));
    check_eq("rst_rdata", read_data, LW'(0));
    rst = 0;

    do_op(1, 32'h1000, {16{8'hA5}});
    do_op(0, 32'h1000, '0);
    mem_q[32'h2000] = {4{32'hDEAD_BEEF}};
    do_op(0, 32'h2000, '0);
    do_op(0, 32'h2000, '0);
    for (int i = 1; i <= 4; i++) do_op(1, 32'(i) << 12, {4{$urandom}});
    do_op(0, 32'h1000, '0);
    do_op(1, 32'h5000, {4{$urandom}});
    do_op(0, 32'h1000, '0);
    do_op(0, 32'h2000, '0);
    do_op(0, 32'h6000, '0);

    // Reset while a refill is outstanding; set 5 is empty so no writeback first.
    @(negedge clk);
    read_req = 1; addr = 32'h7050;
    @(negedge clk);
    read_req = 0;
    for (int c = 0; c < 20 && !mem_read_req; c++) @(negedge clk);
    check_eq("pre_rst_mrd", LW'(mem_read_req), LW'(1));
    rst = 1;
    @(negedge clk);
    check_eq("mid_rst_mrd", LW'(mem_read_req), LW'(0));
    check_eq("mid_rst_ready", LW'(ready), LW'(0));
    rst = 0;
    lines.delete();
    do_op(0, 32'h1000, '0);

    do_op(1, 32'h1000, {4{$urandom}});
    do_op(0, 32'h100C, '0);
    do_op(0, 32'hFFFF_FFFF, '0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 2))
        0:       st = 0;
        1:       st = 1;
        default: st = 63;
      endcase
      a = (32'($urandom_range(1, 6)) << 12) | (32'(st) << 4) | 32'($urandom_range(0, 15));
      do_op(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
